// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared definitions for the OpenMIPS execute stage.
// Holds the operand/result widths, every aluop/alusel code the execute
// stage decodes (including the multiply and HI/LO move additions), the
// multiply FSM state encoding, ZeroWord, and a small absolute-value helper.
package ex_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 8;
    localparam int ALUSEL_W   = 3;

    localparam logic [DATA_W-1:0] ZeroWord = '0;

    // aluop codes
    localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [ALUOP_W-1:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [ALUOP_W-1:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [ALUOP_W-1:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [ALUOP_W-1:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [ALUOP_W-1:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [ALUOP_W-1:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [ALUOP_W-1:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [ALUOP_W-1:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;

    // alusel (result class) codes
    localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [ALUSEL_W-1:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [ALUSEL_W-1:0] EXE_RES_MUL   = 3'b101;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    // Magnitude of a two's-complement word; 0x8000_0000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? -x : x;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: bundle between the ID/EX register (master) and the execute
// stage (slave).
//   *_i : decoded operation, operands, destination and flush from upstream
//   *_o : write-back result, destination, stall request and HI/LO contents
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic [ALUOP_W-1:0]    aluop_i;
    logic [ALUSEL_W-1:0]   alusel_i;
    logic [DATA_W-1:0]     reg1_i;
    logic [DATA_W-1:0]     reg2_i;
    logic [REG_ADDR_W-1:0] wd_i;
    logic                  wreg_i;
    logic                  flush_i;

    logic [REG_ADDR_W-1:0] wd_o;
    logic                  wreg_o;
    logic [DATA_W-1:0]     wdata_o;
    logic                  stall_req_o;
    logic [DATA_W-1:0]     hi_o;
    logic [DATA_W-1:0]     lo_o;

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
        input  wd_o, wreg_o, wdata_o, stall_req_o, hi_o, lo_o
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
        output wd_o, wreg_o, wdata_o, stall_req_o, hi_o, lo_o
    );

endinterface

// File: rtl/ex_stage_mul_iter.sv
// mul_iter: iterative 32-step shift-add multiplier for MULT/MULTU.
//   clk, reset      : clock, synchronous active-high reset
//   start           : multiply presented; honoured only in IDLE
//   flush           : abort; next state IDLE, accumulator discarded
//   op_signed       : 1 = MULT (signed), 0 = MULTU
//   op_a, op_b      : operands
//   busy            : state is BUSY
//   done            : state is DONE; product is valid this cycle
//   product         : sign-corrected 64-bit result
module mul_iter
    import ex_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  flush,
    input  logic                  op_signed,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    mul_state_e            state_q, state_d;
    logic [4:0]            count_q, count_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    // Multiplicand is kept pre-shifted, so mcand_q == captured_a << count_q.
    logic [2*DATA_W-1:0]   mcand_q, mcand_d;
    logic [DATA_W-1:0]     mplier_q, mplier_d;
    logic                  neg_q, neg_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;

        case (state_q)
            MUL_IDLE: begin
                if (start) begin
                    mcand_d  = {{DATA_W{1'b0}}, (op_signed ? abs_val(op_a) : op_a)};
                    mplier_d = op_signed ? abs_val(op_b) : op_b;
                    neg_d    = op_signed & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = MUL_DONE;
                end
            end
            // The multiply is still held on the inputs here; always return
            // to IDLE so it is not restarted.
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase

        if (flush) begin
            state_d = MUL_IDLE;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MUL_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
        end
    end

    assign busy    = (state_q == MUL_BUSY);
    assign done    = (state_q == MUL_DONE);
    assign product = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage OpenMIPS pipeline.
//   clk, reset : clock, synchronous active-high reset
//   ex         : ex_stage_if.slave
//                in : aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i
//                out: wd_o, wreg_o, wdata_o, stall_req_o, hi_o, lo_o
// Logic/shift/move results are combinational. MULT/MULTU run on mul_iter
// and stall the pipeline; the result lands in the HI/LO registers owned here.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    ex_stage_if.slave  ex
);

    logic                  is_mul_op;
    logic                  mul_start;
    logic                  mul_busy;
    logic                  mul_done;
    logic [2*DATA_W-1:0]   mul_product;

    logic [DATA_W-1:0]     hi_q, hi_d;
    logic [DATA_W-1:0]     lo_q, lo_d;

    logic [DATA_W-1:0]     logic_res;
    logic [DATA_W-1:0]     shift_res;
    logic [DATA_W-1:0]     move_res;
    logic [DATA_W-1:0]     wdata;
    logic [4:0]            shamt;

    assign is_mul_op = (ex.aluop_i == EXE_MULT_OP) || (ex.aluop_i == EXE_MULTU_OP);
    assign mul_start = is_mul_op & ~ex.flush_i;
    assign shamt     = ex.reg1_i[4:0];

    mul_iter u_mul_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (mul_start),
        .flush     (ex.flush_i),
        .op_signed (ex.aluop_i == EXE_MULT_OP),
        .op_a      (ex.reg1_i),
        .op_b      (ex.reg2_i),
        .busy      (mul_busy),
        .done      (mul_done),
        .product   (mul_product)
    );

    always_comb begin
        logic_res = ZeroWord;
        case (ex.aluop_i)
            EXE_OR_OP:  logic_res = ex.reg1_i | ex.reg2_i;
            EXE_AND_OP: logic_res = ex.reg1_i & ex.reg2_i;
            EXE_XOR_OP: logic_res = ex.reg1_i ^ ex.reg2_i;
            EXE_NOR_OP: logic_res = ~(ex.reg1_i | ex.reg2_i);
            default:    logic_res = ZeroWord;
        endcase
    end

    always_comb begin
        shift_res = ZeroWord;
        case (ex.aluop_i)
            EXE_SLL_OP: shift_res = ex.reg2_i << shamt;
            EXE_SRL_OP: shift_res = ex.reg2_i >> shamt;
            EXE_SRA_OP: shift_res = $unsigned($signed(ex.reg2_i) >>> shamt);
            default:    shift_res = ZeroWord;
        endcase
    end

    always_comb begin
        move_res = ZeroWord;
        case (ex.aluop_i)
            EXE_MFHI_OP: move_res = hi_q;
            EXE_MFLO_OP: move_res = lo_q;
            default:     move_res = ZeroWord;
        endcase
    end

    always_comb begin
        wdata = ZeroWord;
        case (ex.alusel_i)
            EXE_RES_LOGIC: wdata = logic_res;
            EXE_RES_SHIFT: wdata = shift_res;
            EXE_RES_MOVE:  wdata = move_res;
            default:       wdata = ZeroWord;
        endcase
    end

    // HI/LO take the product on the edge that ends DONE unless flushed.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (mul_done && !ex.flush_i) begin
            hi_d = mul_product[2*DATA_W-1:DATA_W];
            lo_d = mul_product[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= ZeroWord;
            lo_q <= ZeroWord;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign ex.wd_o        = ex.wd_i;
    assign ex.wreg_o      = ex.wreg_i & ~is_mul_op & ~mul_busy;
    assign ex.wdata_o     = wdata;
    // A multiply presented in IDLE (neither BUSY nor DONE) stalls at once.
    assign ex.stall_req_o = mul_busy | (mul_start & ~mul_done);
    assign ex.hi_o        = hi_q;
    assign ex.lo_o        = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
`timescale 1ns/1ps
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    ex_stage_if bus();

    ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .ex    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [4:0] wd, input logic wreg, input logic fl);
        bus.aluop_i  = op;
        bus.alusel_i = sel;
        bus.reg1_i   = r1;
        bus.reg2_i   = r2;
        bus.wd_i     = wd;
        bus.wreg_i   = wreg;
        bus.flush_i  = fl;
    endtask

    // Behavioural result of a single-cycle operation.
    function automatic logic [31:0] ref_alu(input logic [2:0] sel, input logic [7:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        int s;
        logic [31:0] fill;
        s = int'(a[4:0]);
        fill = b[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0;
        if (sel == EXE_RES_LOGIC) begin
            if (op == EXE_OR_OP)  return a | b;
            if (op == EXE_AND_OP) return a & b;
            if (op == EXE_XOR_OP) return a ^ b;
            if (op == EXE_NOR_OP) return ~(a | b);
            return 32'h0;
        end
        if (sel == EXE_RES_SHIFT) begin
            if (op == EXE_SLL_OP) return b << s;
            if (op == EXE_SRL_OP) return b >> s;
            if (op == EXE_SRA_OP) return (b >> s) | fill;
            return 32'h0;
        end
        if (sel == EXE_RES_MOVE) begin
            if (op == EXE_MFHI_OP) return m_hi;
            if (op == EXE_MFLO_OP) return m_lo;
            return 32'h0;
        end
        return 32'h0;
    endfunction

    // Starts a multiply at the current negedge and follows it to completion.
    // Returns at negedge+1 of the cycle after DONE, with the multiply still
    // driven; the caller drives the next instruction immediately.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input bit sgn, input string tag);
        int n;
        int bad_wreg;
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] p;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            p  = sa * sb;
        end else begin
            ua = a;
            ub = b;
            p  = ua * ub;
        end
        drive(sgn ? EXE_MULT_OP : EXE_MULTU_OP, EXE_RES_MUL, a, b, 5'd9, 1'b1, 1'b0);
        n = 0;
        bad_wreg = 0;
        #2;
        while (bus.stall_req_o === 1'b1 && n < 100) begin
            n++;
            if (bus.wreg_o !== 1'b0) bad_wreg++;
            @(negedge clk);
            #2;
        end
        n_cmp++;
        if (n !== 33) begin
            n_fail++;
            $display("FAIL %s stall_cycles: got %0d expected 33", tag, n);
        end
        n_cmp++;
        if (bad_wreg !== 0) begin
            n_fail++;
            $display("FAIL %s wreg_during_stall: got %0d cycles with wreg_o=1 expected 0", tag, bad_wreg);
        end
        n_cmp++;
        if (bus.wreg_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s wreg_in_done: got %b expected 0", tag, bus.wreg_o);
        end
        n_cmp++;
        if (bus.hi_o !== m_hi || bus.lo_o !== m_lo) begin
            n_fail++;
            $display("FAIL %s hilo_before_done_edge: got %h_%h expected %h_%h", tag, bus.hi_o, bus.lo_o, m_hi, m_lo);
        end
        @(negedge clk);
        #1;
        m_hi = p[63:32];
        m_lo = p[31:0];
        n_cmp++;
        if (bus.hi_o !== m_hi || bus.lo_o !== m_lo) begin
            n_fail++;
            $display("FAIL %s hilo: got %h_%h expected %h_%h", tag, bus.hi_o, bus.lo_o, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #2;
        m_hi = 32'h0;
        m_lo = 32'h0;
        n_cmp++;
        if (bus.stall_req_o !== 1'b0 || bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: stall=%b hi=%h lo=%h expected 0/0/0", bus.stall_req_o, bus.hi_o, bus.lo_o);
        end
        n_cmp++;
        if (bus.wreg_o !== 1'b0 || bus.wdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: wreg=%b wdata=%h expected 0/0", bus.wreg_o, bus.wdata_o);
        end
    endtask

    task automatic test_directed_alu();
        @(negedge clk);
        drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_FF00, 32'h0F0F_0F0F, 5'd3, 1'b1, 1'b0);
        #2;
        n_cmp++;
        if (bus.wdata_o !== 32'h0F0F_FF0F || bus.wreg_o !== 1'b1 || bus.wd_o !== 5'd3 || bus.stall_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL or_directed: wdata=%h wreg=%b wd=%0d stall=%b expected 0f0fff0f/1/3/0",
                     bus.wdata_o, bus.wreg_o, bus.wd_o, bus.stall_req_o);
        end
        @(negedge clk);
        drive(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 5'd4, 1'b1, 1'b0);
        #2;
        n_cmp++;
        if (bus.wdata_o !== 32'hF800_0000) begin
            n_fail++;
            $display("FAIL sra_directed: got %h expected f8000000", bus.wdata_o);
        end
        @(negedge clk);
        drive(EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 5'd4, 1'b1, 1'b0);
        #2;
        n_cmp++;
        if (bus.wdata_o !== 32'h0800_0000) begin
            n_fail++;
            $display("FAIL srl_directed: got %h expected 08000000", bus.wdata_o);
        end
    endtask

    task automatic test_random_alu();
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] a, b, exp;
        logic [4:0]  wd;
        logic        wr;
        int          k;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            k  = int'($urandom_range(0, 9));
            a  = $urandom;
            b  = $urandom;
            wd = 5'($urandom_range(0, 31));
            wr = 1'($urandom_range(0, 1));
            case (k)
                0: begin op = EXE_OR_OP;   sel = EXE_RES_LOGIC; end
                1: begin op = EXE_AND_OP;  sel = EXE_RES_LOGIC; end
                2: begin op = EXE_XOR_OP;  sel = EXE_RES_LOGIC; end
                3: begin op = EXE_NOR_OP;  sel = EXE_RES_LOGIC; end
                4: begin op = EXE_SLL_OP;  sel = EXE_RES_SHIFT; end
                5: begin op = EXE_SRL_OP;  sel = EXE_RES_SHIFT; end
                6: begin op = EXE_SRA_OP;  sel = EXE_RES_SHIFT; end
                7: begin op = EXE_MFHI_OP; sel = EXE_RES_MOVE;  end
                8: begin op = EXE_MFLO_OP; sel = EXE_RES_MOVE;  end
                default: begin op = EXE_OR_OP; sel = 3'b111; end
            endcase
            drive(op, sel, a, b, wd, wr, 1'b0);
            exp = ref_alu(sel, op, a, b);
            #2;
            n_cmp++;
            if (bus.wdata_o !== exp) begin
                n_fail++;
                $display("FAIL rand_alu_wdata[%0d]: op=%h sel=%0d a=%h b=%h got %h expected %h",
                         i, op, sel, a, b, bus.wdata_o, exp);
            end
            n_cmp++;
            if (bus.wreg_o !== wr || bus.wd_o !== wd || bus.stall_req_o !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_alu_ctrl[%0d]: wreg=%b wd=%0d stall=%b expected %b/%0d/0",
                         i, bus.wreg_o, bus.wd_o, bus.stall_req_o, wr, wd);
            end
        end
    endtask

    task automatic test_mul_directed();
        @(negedge clk);
        run_mul(32'hFFFF_FFFF, 32'd2, 1'b0, "multu_ffffffff_x2");
        n_cmp++;
        if (bus.hi_o !== 32'h0000_0001 || bus.lo_o !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL multu_const: got %h_%h expected 00000001_fffffffe", bus.hi_o, bus.lo_o);
        end
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        run_mul(-32'sd3, 32'd7, 1'b1, "mult_m3_x7");
        n_cmp++;
        if (bus.hi_o !== 32'hFFFF_FFFF || bus.lo_o !== 32'hFFFF_FFEB) begin
            n_fail++;
            $display("FAIL mult_const: got %h_%h expected ffffffff_ffffffeb", bus.hi_o, bus.lo_o);
        end
        drive(EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0);
        #2;
        n_cmp++;
        if (bus.wdata_o !== 32'hFFFF_FFEB || bus.wreg_o !== 1'b1 || bus.stall_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mflo_after_mult: wdata=%h wreg=%b stall=%b expected ffffffeb/1/0",
                     bus.wdata_o, bus.wreg_o, bus.stall_req_o);
        end
        @(negedge clk);
        run_mul(32'h8000_0000, 32'h8000_0000, 1'b1, "mult_min_x_min");
        drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0);
        #2;
        n_cmp++;
        if (bus.wdata_o !== 32'h4000_0000) begin
            n_fail++;
            $display("FAIL mfhi_min_x_min: got %h expected 40000000", bus.wdata_o);
        end
    endtask

    task automatic test_mul_random();
        logic [31:0] a, b;
        bit sgn;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a   = $urandom;
            b   = $urandom;
            sgn = 1'($urandom_range(0, 1));
            run_mul(a, b, sgn, $sformatf("rand_mul%0d", i));
            drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        run_mul(32'd1000, 32'hFFFF_FFF0, 1'b1, "b2b_first");
        run_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, "b2b_second");
        drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0);
        #2;
        n_cmp++;
        if (bus.wdata_o !== m_hi) begin
            n_fail++;
            $display("FAIL b2b_mfhi: got %h expected %h", bus.wdata_o, m_hi);
        end
    endtask

    task automatic test_flush();
        int n;
        @(negedge clk);
        run_mul(32'h0005_0000, 32'h0001_0000, 1'b0, "seed_hi5");
        drive(EXE_MULT_OP, EXE_RES_MUL, 32'd123, 32'd456, 5'd1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        bus.flush_i = 1'b1;
        #2;
        n_cmp++;
        if (bus.stall_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_busy_stall: got %b expected 1", bus.stall_req_o);
        end
        @(negedge clk);
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        #2;
        n_cmp++;
        if (bus.stall_req_o !== 1'b0 || bus.hi_o !== 32'h5 || bus.lo_o !== m_lo) begin
            n_fail++;
            $display("FAIL flush_busy_after: stall=%b hi=%h lo=%h expected 0/00000005/%h",
                     bus.stall_req_o, bus.hi_o, bus.lo_o, m_lo);
        end
        repeat (40) @(negedge clk);
        #1;
        n_cmp++;
        if (bus.stall_req_o !== 1'b0 || bus.hi_o !== m_hi || bus.lo_o !== m_lo) begin
            n_fail++;
            $display("FAIL flush_no_late_write: stall=%b hi=%h lo=%h expected 0/%h/%h",
                     bus.stall_req_o, bus.hi_o, bus.lo_o, m_hi, m_lo);
        end
        // Flush landing in DONE must also suppress the HI/LO write.
        drive(EXE_MULTU_OP, EXE_RES_MUL, 32'd7, 32'd7, 5'd1, 1'b1, 1'b0);
        n = 0;
        #2;
        while (bus.stall_req_o === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #2;
        end
        bus.flush_i = 1'b1;
        @(negedge clk);
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (n !== 33 || bus.hi_o !== m_hi || bus.lo_o !== m_lo) begin
            n_fail++;
            $display("FAIL flush_in_done: stall_cycles=%0d hi=%h lo=%h expected 33/%h/%h",
                     n, bus.hi_o, bus.lo_o, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        drive(EXE_MULT_OP, EXE_RES_MUL, 32'd3, 32'd4, 5'd1, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        m_hi = 32'h0;
        m_lo = 32'h0;
        n_cmp++;
        if (bus.stall_req_o !== 1'b0 || bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: stall=%b hi=%h lo=%h expected 0/0/0",
                     bus.stall_req_o, bus.hi_o, bus.lo_o);
        end
        @(negedge clk);
        run_mul(32'd6, 32'd7, 1'b1, "mult_6x7_after_reset");
        n_cmp++;
        if (bus.lo_o !== 32'd42) begin
            n_fail++;
            $display("FAIL lo_42: got %h expected 0000002a", bus.lo_o);
        end
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        m_hi   = 32'h0;
        m_lo   = 32'h0;
        test_reset();
        test_directed_alu();
        test_random_alu();
        test_mul_directed();
        test_mul_random();
        test_back_to_back();
        test_flush();
        test_reset_mid_busy();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
